stopwatch_lap_timer: RTL and testbench
======================================

Name: stopwatch_lap_timer

Overview:
Parametrised successor to the stopwatch_top timer. It provides a configurable second prescaler, configurable minute width, and up-count or count-down modes with preload and expiry. A LAP_DEPTH-entry lap FIFO captures split times. It sits between the debounced button/control logic and the display/readout logic, and reuses the existing 2-bit status convention.

Parameters:
CLK_DIV, 100, clk cycles per one-second tick (>=2)
MIN_WIDTH, 8, width of the minutes counter
LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  run request (level, sampled each cycle)
stop  in  1  pause request
clear  in  1  user reset: time, prescaler, FIFO, flags to zero; go IDLE
mode_down  in  1  1 = countdown; latched only on IDLE->RUN
load  in  1  preload time from load_min/load_sec (IDLE/PAUSE only)
load_min  in  MIN_WIDTH  preload minutes
load_sec  in  6  preload seconds (values >59 clamp to 59)
lap  in  1  capture current time into lap FIFO (RUN/PAUSE only)
lap_rd  in  1  pop FIFO head when lap_valid
minutes  out  MIN_WIDTH  current minutes
seconds  out  6  current seconds 0..59
status  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED
expired  out  1  one-cycle pulse on entering EXPIRED
lap_valid  out  1  FIFO non-empty
lap_min  out  MIN_WIDTH  FIFO head minutes
lap_sec  out  6  FIFO head seconds
lap_count  out  $clog2(LAP_DEPTH)+1  FIFO occupancy
lap_overflow  out  1  sticky: a lap was dropped because the FIFO was full

Behaviour:
- rst (clk edge, rst=1): all outputs 0, status IDLE, prescaler 0, FIFO empty, mode register = up.
- Control priority, one per cycle: clear > load > stop > start. lap and lap_rd are independent of these.
- IDLE: start -> RUN; mode register <= mode_down. In down mode, start with time 00:00 is ignored (stay IDLE).
- RUN: stop -> PAUSE. The prescaler increments each cycle; tick when prescaler == CLK_DIV-1, then prescaler <= 0.
- PAUSE: start -> RUN. The prescaler holds its value, so the fractional second is preserved. load is allowed.
- EXPIRED: only clear or rst leave (-> IDLE). start, stop, load and lap are ignored.
- All outputs are registered. start in cycle N -> status=01 in N+1. With the prescaler at 0, the first tick takes effect CLK_DIV cycles after RUN entry.
- Up tick: seconds 59 -> 0 with minutes+1. At max minutes and 59 s, wrap to 00:00 and keep running.
- Down tick: seconds 0 -> 59 with minutes-1. The tick that yields 00:00 moves to EXPIRED with the time held at 00:00, and expired pulses for 1 cycle.
- load in RUN or EXPIRED is ignored. load does not change the prescaler.
- lap captures the pre-tick {minutes,seconds} of the same cycle.
- FIFO full + lap without lap_rd: the capture is dropped and lap_overflow <= 1.
- FIFO full + lap + lap_rd in the same cycle: pop and push both occur; count unchanged; no overflow.
- FIFO empty + lap + lap_rd in the same cycle: push only (lap_rd ignored).
- lap_rd while empty: no effect.
- lap_min/lap_sec show the head entry combinationally from FIFO storage. They are 0 when empty.
- clear mid-RUN: next cycle shows 00:00, IDLE, FIFO empty, lap_overflow 0, prescaler 0.

Optional Feature:
LAP_SPLIT_EN
- Defined: each FIFO entry stores the delta from the previous capture rather than absolute time.
  - Up mode: delta = current − previous; down mode: delta = previous − current. Computed as mm:ss with borrow from minutes.
  - The previous-capture register is zeroed on rst, on clear and on IDLE->RUN. In down mode it is set to the loaded time on IDLE->RUN.
  - Dropped (overflowed) captures still update the previous-capture register.
- Undefined: entries store absolute time, and no previous-capture register exists.

Test Plan:
CLK_DIV=4, MIN_WIDTH=8, LAP_DEPTH=4 throughout.
- rst 2 cycles, start 1 cycle, run 244 cycles -> status=01 next cycle, 01:01 shown (61 ticks), expired never pulses.
- Start, run 10 cycles, stop 1 cycle, wait 20, start again -> time 00:02 during PAUSE. Prescaler resumes from 2, so the 3rd tick lands 2 cycles after RUN re-entry.
- load 00:02 in IDLE, mode_down=1, start -> 00:01 after 4 cycles, 00:00 after 8. status=11 and expired high for exactly 1 cycle; further start ignored; clear -> IDLE 00:00.
- Start up mode; lap at 00:01, 00:03, 00:04, 00:06, 00:07 without lap_rd -> lap_count=4 and lap_overflow=1. Pops return 00:01, 00:03, 00:04, 00:06.
  - With LAP_SPLIT_EN defined, pops return 00:01, 00:02, 00:01, 00:02.
- Load 255:59 with mode_down=0, start -> one tick later 00:00 with status still 01.
- FIFO full; lap and lap_rd in the same cycle -> head advances, tail receives the new time, lap_count stays 4, lap_overflow unchanged. A clear mid-RUN then gives lap_count=0 and 00:00 next cycle.

Source files
------------

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with prescaled second tick, up/down counting, preload/expiry and a lap FIFO.
// Optional feature macro LAP_SPLIT_EN: lap entries hold the split since the previous capture.
module stopwatch_lap_timer #(
    parameter int CLK_DIV   = 100,
    parameter int MIN_WIDTH = 8,
    parameter int LAP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       mode_down,
    input  logic                       load,
    input  logic [MIN_WIDTH-1:0]       load_min,
    input  logic [5:0]                 load_sec,
    input  logic                       lap,
    input  logic                       lap_rd,
    output logic [MIN_WIDTH-1:0]       minutes,
    output logic [5:0]                 seconds,
    output logic [1:0]                 status,
    output logic                       expired,
    output logic                       lap_valid,
    output logic [MIN_WIDTH-1:0]       lap_min,
    output logic [5:0]                 lap_sec,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       lap_overflow
);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam int TW = MIN_WIDTH + 6;

    localparam logic [PW-1:0]        PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]        PRE_ZERO  = PW'(1'b0);
    localparam logic [PW-1:0]        PRE_ONE   = PW'(1'b1);
    localparam logic [MIN_WIDTH-1:0] MIN_ZERO  = MIN_WIDTH'(1'b0);
    localparam logic [MIN_WIDTH-1:0] MIN_ONE   = MIN_WIDTH'(1'b1);
    localparam logic [CW-1:0]        CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0]        CNT_FULL  = CW'(LAP_DEPTH);
    localparam logic [AW-1:0]        PTR_ZERO  = AW'(1'b0);
    localparam logic [AW-1:0]        PTR_ONE   = AW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    state_t               state_r;
    logic                 mode_down_r;
    logic [PW-1:0]        presc_r;
    logic [TW-1:0]        fifo_mem_r [LAP_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;

    logic                 tick_s;
    logic                 load_ok_s;
    logic                 at_zero_s;
    logic                 go_run_s;
    logic                 down_hits_zero_s;
    logic [5:0]           load_sec_s;
    logic [MIN_WIDTH-1:0] up_min_s;
    logic [5:0]           up_sec_s;
    logic [MIN_WIDTH-1:0] dn_min_s;
    logic [5:0]           dn_sec_s;
    logic                 lap_ok_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic [CW-1:0]        count_nxt_s;
    logic [TW-1:0]        cur_s;
    logic [TW-1:0]        cap_s;
    logic [TW-1:0]        head_s;

    assign status = state_r;

`ifdef LAP_SPLIT_EN
    logic [TW-1:0] prev_r;

    // mm:ss subtraction a - b with borrow from minutes; minutes wrap modulo 2^MIN_WIDTH.
    function automatic logic [TW-1:0] time_sub(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [MIN_WIDTH-1:0] m;
        logic [5:0]           s;
        if (a[5:0] >= b[5:0]) begin
            s = a[5:0] - b[5:0];
            m = a[TW-1:6] - b[TW-1:6];
        end else begin
            s = a[5:0] + 6'd60 - b[5:0];
            m = a[TW-1:6] - b[TW-1:6] - MIN_ONE;
        end
        return {m, s};
    endfunction
`endif

    // Control decode, next-time candidates and FIFO handshake.
    always_comb begin
        cur_s            = {minutes, seconds};
        tick_s           = (state_r == ST_RUN) && (presc_r == PRE_LAST);
        load_ok_s        = load && ((state_r == ST_IDLE) || (state_r == ST_PAUSE));
        at_zero_s        = (minutes == MIN_ZERO) && (seconds == 6'd0);
        go_run_s         = (state_r == ST_IDLE) && !load_ok_s && !stop && start
                           && !(mode_down && at_zero_s);
        load_sec_s       = (load_sec > 6'd59) ? 6'd59 : load_sec;
        down_hits_zero_s = (minutes == MIN_ZERO) && (seconds == 6'd1);
        if (seconds == 6'd59) begin
            up_sec_s = 6'd0;
            up_min_s = minutes + MIN_ONE;
        end else begin
            up_sec_s = seconds + 6'd1;
            up_min_s = minutes;
        end
        if (seconds == 6'd0) begin
            dn_sec_s = 6'd59;
            dn_min_s = minutes - MIN_ONE;
        end else begin
            dn_sec_s = seconds - 6'd1;
            dn_min_s = minutes;
        end
        lap_ok_s = lap && ((state_r == ST_RUN) || (state_r == ST_PAUSE));
        full_s   = (lap_count == CNT_FULL);
        pop_s    = lap_rd && lap_valid;
        push_s   = lap_ok_s && (!full_s || pop_s);
        drop_s   = lap_ok_s && full_s && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = lap_count + CNT_ONE;
            2'b01:   count_nxt_s = lap_count - CNT_ONE;
            default: count_nxt_s = lap_count;
        endcase
`ifdef LAP_SPLIT_EN
        cap_s = mode_down_r ? time_sub(prev_r, cur_s) : time_sub(cur_s, prev_r);
`else
        cap_s = cur_s;
`endif
        head_s = fifo_mem_r[rd_ptr_r];
        if (lap_valid) begin
            lap_min = head_s[TW-1:6];
            lap_sec = head_s[5:0];
        end else begin
            lap_min = MIN_ZERO;
            lap_sec = 6'd0;
        end
    end

    // Run-state machine, prescaler and displayed time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mode_down_r <= 1'b0;
            presc_r     <= PRE_ZERO;
            minutes     <= MIN_ZERO;
            seconds     <= 6'd0;
            expired     <= 1'b0;
        end else if (clear) begin
            state_r <= ST_IDLE;
            presc_r <= PRE_ZERO;
            minutes <= MIN_ZERO;
            seconds <= 6'd0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_ok_s) begin
                        minutes <= load_min;
                        seconds <= load_sec_s;
                    end else if (go_run_s) begin
                        state_r     <= ST_RUN;
                        mode_down_r <= mode_down;
                    end
                end
                ST_RUN: begin
                    presc_r <= tick_s ? PRE_ZERO : presc_r + PRE_ONE;
                    if (tick_s) begin
                        minutes <= mode_down_r ? dn_min_s : up_min_s;
                        seconds <= mode_down_r ? dn_sec_s : up_sec_s;
                    end
                    // Expiry outranks a simultaneous stop so the 00:00 state is never paused.
                    if (tick_s && mode_down_r && down_hits_zero_s) begin
                        state_r <= ST_EXPIRED;
                        expired <= 1'b1;
                    end else if (stop) begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (load_ok_s) begin
                        minutes <= load_min;
                        seconds <= load_sec_s;
                    end else if (start && !stop) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_EXPIRED: state_r <= ST_EXPIRED;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Lap FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            lap_count    <= CNT_ZERO;
            lap_valid    <= 1'b0;
            lap_overflow <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            lap_count <= count_nxt_s;
            lap_valid <= (count_nxt_s != CNT_ZERO);
            if (drop_s) begin
                lap_overflow <= 1'b1;
            end
        end
    end

    // Lap storage holds data only; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push_s && !rst && !clear) begin
            fifo_mem_r[wr_ptr_r] <= cap_s;
        end
    end

`ifdef LAP_SPLIT_EN
    // Reference point for split deltas; dropped captures still advance it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev_r <= {TW{1'b0}};
        end else if (go_run_s) begin
            prev_r <= mode_down ? cur_s : {TW{1'b0}};
        end else if (lap_ok_s) begin
            prev_r <= cur_s;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Self-checking bench: total-seconds behavioural model compared every cycle, plus directed literal checks.
module tb_stopwatch_lap_timer;
    localparam int CLK_DIV   = 4;
    localparam int MIN_WIDTH = 8;
    localparam int LAP_DEPTH = 4;
    localparam int TMAX      = (1 << MIN_WIDTH) * 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, mode_down = 1'b0, load = 1'b0;
    logic [7:0] load_min = 8'd0;
    logic [5:0] load_sec = 6'd0;
    logic       lap = 1'b0, lap_rd = 1'b0;
    logic [7:0] minutes, lap_min;
    logic [5:0] seconds, lap_sec;
    logic [1:0] status;
    logic       expired, lap_valid, lap_overflow;
    logic [2:0] lap_count;

    stopwatch_lap_timer #(.CLK_DIV(CLK_DIV), .MIN_WIDTH(MIN_WIDTH), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
        .lap(lap), .lap_rd(lap_rd), .minutes(minutes), .seconds(seconds),
        .status(status), .expired(expired), .lap_valid(lap_valid), .lap_min(lap_min),
        .lap_sec(lap_sec), .lap_count(lap_count), .lap_overflow(lap_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: time as total seconds, state as 0 idle/1 run/2 pause/3 expired, FIFO as a queue.
    int m_st = 0, m_t = 0, m_pre = 0;
    bit m_down = 1'b0, m_exp = 1'b0, m_ovf = 1'b0;
    int q[$];
`ifdef LAP_SPLIT_EN
    int m_prev = 0;
`endif

    always @(posedge clk) begin
        int  cur;
        bit  full, pop_now;
        if (rst) begin
            m_st = 0; m_t = 0; m_pre = 0; m_down = 1'b0; m_exp = 1'b0; m_ovf = 1'b0; q.delete();
`ifdef LAP_SPLIT_EN
            m_prev = 0;
`endif
        end else if (clear) begin
            m_st = 0; m_t = 0; m_pre = 0; m_exp = 1'b0; m_ovf = 1'b0; q.delete();
`ifdef LAP_SPLIT_EN
            m_prev = 0;
`endif
        end else begin
            m_exp   = 1'b0;
            cur     = m_t;
            full    = (q.size() == LAP_DEPTH);
            pop_now = lap_rd && (q.size() > 0);
            if (pop_now) void'(q.pop_front());
            if (lap && (m_st == 1 || m_st == 2)) begin
                int v;
`ifdef LAP_SPLIT_EN
                v = m_down ? (m_prev - cur + TMAX) % TMAX : (cur - m_prev + TMAX) % TMAX;
                m_prev = cur;
`else
                v = cur;
`endif
                if (!full || pop_now) q.push_back(v);
                else m_ovf = 1'b1;
            end
            case (m_st)
                0: begin
                    if (load) m_t = int'(load_min) * 60 + ((int'(load_sec) > 59) ? 59 : int'(load_sec));
                    else if (!stop && start && !(mode_down && m_t == 0)) begin
                        m_st = 1;
                        m_down = mode_down;
`ifdef LAP_SPLIT_EN
                        m_prev = mode_down ? m_t : 0;
`endif
                    end
                end
                1: begin
                    m_pre++;
                    if (m_pre == CLK_DIV) begin
                        m_pre = 0;
                        if (!m_down) m_t = (m_t + 1) % TMAX;
                        else begin
                            m_t = (m_t - 1 + TMAX) % TMAX;
                            if (m_t == 0) begin m_st = 3; m_exp = 1'b1; end
                        end
                    end
                    if (m_st == 1 && stop) m_st = 2;
                end
                2: begin
                    if (load) m_t = int'(load_min) * 60 + ((int'(load_sec) > 59) ? 59 : int'(load_sec));
                    else if (!stop && start) m_st = 1;
                end
                default: ;
            endcase
        end
    end

    bit chk_en = 1'b0;
    bit exp_seen = 1'b0;

    // Compare every output to the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("minutes", int'(minutes), m_t / 60);
            check("seconds", int'(seconds), m_t % 60);
            check("status", int'(status), m_st);
            check("expired", int'(expired), int'(m_exp));
            check("lap_count", int'(lap_count), q.size());
            check("lap_valid", int'(lap_valid), int'(q.size() > 0));
            check("lap_overflow", int'(lap_overflow), int'(m_ovf));
            check("lap_min", int'(lap_min), (q.size() > 0) ? q[0] / 60 : 0);
            check("lap_sec", int'(lap_sec), (q.size() > 0) ? q[0] % 60 : 0);
            if (expired) exp_seen = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_model(input int t);
        int k = 0;
        while (m_t != t && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("wait_time_reached", m_t, t);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic pulse_start(input logic down);
        mode_down = down; start = 1'b1; step(1); start = 1'b0; mode_down = 1'b0;
    endtask

    task automatic do_lap(input int t);
        wait_model(t);
        lap = 1'b1; step(1); lap = 1'b0;
    endtask

`ifdef LAP_SPLIT_EN
    int exp_pop[4]  = '{1, 2, 1, 2};
    int exp_head    = 1;
    int exp_tail    = 2;
`else
    int exp_pop[4]  = '{1, 3, 4, 6};
    int exp_head    = 1;
    int exp_tail    = 5;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_status", int'(status), 0);
        check("rst_minutes", int'(minutes), 0);
        check("rst_lap_count", int'(lap_count), 0);

        // Free run: 61 ticks in 244 cycles.
        pulse_start(1'b0);
        check("t1_status_run", int'(status), 1);
        step(244);
        check("t1_min", int'(minutes), 1);
        check("t1_sec", int'(seconds), 1);
        check("t1_no_expired", int'(exp_seen), 0);
        pulse_clear();
        check("t1_clear_status", int'(status), 0);
        check("t1_clear_sec", int'(seconds), 0);

        // Pause keeps the fractional second.
        pulse_start(1'b0);
        step(9);
        stop = 1'b1; step(1); stop = 1'b0;
        check("t2_pause_status", int'(status), 2);
        check("t2_pause_sec", int'(seconds), 2);
        step(20);
        check("t2_hold_sec", int'(seconds), 2);
        pulse_start(1'b0);
        check("t2_resume_status", int'(status), 1);
        step(1);
        check("t2_resume_r1", int'(seconds), 2);
        step(1);
        check("t2_resume_r2", int'(seconds), 3);
        pulse_clear();

        // Countdown from 00:02 to expiry.
        load_min = 8'd0; load_sec = 6'd2; load = 1'b1; step(1); load = 1'b0;
        check("t3_load_sec", int'(seconds), 2);
        pulse_start(1'b1);
        step(4);
        check("t3_sec1", int'(seconds), 1);
        step(3);
        check("t3_sec1_hold", int'(seconds), 1);
        step(1);
        check("t3_sec0", int'(seconds), 0);
        check("t3_expired_status", int'(status), 3);
        check("t3_expired_pulse", int'(expired), 1);
        step(1);
        check("t3_expired_low", int'(expired), 0);
        load_sec = 6'd5; load = 1'b1; start = 1'b1; step(1); load = 1'b0; start = 1'b0;
        check("t3_ignore_start", int'(status), 3);
        check("t3_ignore_load", int'(seconds), 0);
        pulse_clear();
        check("t3_clear_status", int'(status), 0);
        pulse_start(1'b1);
        check("t3_down_zero_start", int'(status), 0);
        load_min = 8'd3; load_sec = 6'd63; load = 1'b1; step(1); load = 1'b0;
        check("t3_clamp_min", int'(minutes), 3);
        check("t3_clamp_sec", int'(seconds), 59);
        pulse_clear();

        // Lap FIFO fill and overflow.
        pulse_start(1'b0);
        do_lap(1); do_lap(3); do_lap(4); do_lap(6); do_lap(7);
        check("t4_count", int'(lap_count), 4);
        check("t4_overflow", int'(lap_overflow), 1);
        for (int i = 0; i < 4; i++) begin
            check("t4_pop_min", int'(lap_min), 0);
            check("t4_pop_sec", int'(lap_sec), exp_pop[i]);
            lap_rd = 1'b1; step(1); lap_rd = 1'b0;
        end
        check("t4_empty_count", int'(lap_count), 0);
        check("t4_empty_valid", int'(lap_valid), 0);
        check("t4_empty_sec", int'(lap_sec), 0);
        pulse_clear();

        // Minute wrap at 255:59.
        load_min = 8'd255; load_sec = 6'd59; load = 1'b1; step(1); load = 1'b0;
        pulse_start(1'b0);
        step(3);
        check("t5_pre_wrap_min", int'(minutes), 255);
        step(1);
        check("t5_wrap_min", int'(minutes), 0);
        check("t5_wrap_sec", int'(seconds), 0);
        check("t5_wrap_status", int'(status), 1);
        pulse_clear();

        // Simultaneous push/pop on empty and full FIFO, then clear mid-run.
        pulse_start(1'b0);
        lap = 1'b1; lap_rd = 1'b1; step(1); lap = 1'b0; lap_rd = 1'b0;
        check("t6_empty_pushpop", int'(lap_count), 1);
        do_lap(1); do_lap(2); do_lap(3);
        check("t6_full", int'(lap_count), 4);
        wait_model(5);
        lap = 1'b1; lap_rd = 1'b1; step(1); lap = 1'b0; lap_rd = 1'b0;
        check("t6_full_count", int'(lap_count), 4);
        check("t6_full_no_ovf", int'(lap_overflow), 0);
        check("t6_head", int'(lap_sec), exp_head);
        lap_rd = 1'b1; step(3); lap_rd = 1'b0;
        check("t6_tail", int'(lap_sec), exp_tail);
        pulse_clear();
        check("t6_clear_count", int'(lap_count), 0);
        check("t6_clear_sec", int'(seconds), 0);
        check("t6_clear_status", int'(status), 0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
